// File: rtl/ahb_spi_flash_xip_if.sv
// AHB-Lite bus bundle between the read-only cache fill port and the SPI flash XIP slave.
// hready is the bus-level ready; hready_resp is the slave's own ready output.
interface ahb_spi_flash_xip_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              hready_resp;
    logic              hready;
    logic              hresp;
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic [W_DATA-1:0] hwdata;
    logic [W_DATA-1:0] hrdata;

    modport master (
        input  hready_resp, hresp, hrdata,
        output hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata
    );

    modport slave (
        output hready_resp, hresp, hrdata,
        input  hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata
    );
endinterface

// File: rtl/ahb_spi_flash_xip.sv
// Read-only AHB-Lite slave serving execute-in-place word reads from SPI NOR flash
// (mode 0, 0x03 READ); sequential words keep the flash transaction open.
module ahb_spi_flash_xip #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    ahb_spi_flash_xip_if.slave  ahbls,
    output logic                spi_cs_n,
    output logic                spi_sclk,
    output logic                spi_mosi,
    input  logic                spi_miso
);
    localparam logic [7:0] CMD_READ = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMDADDR, S_DATA, S_RESP, S_GAP, S_ERR_PH0, S_ERR_PH1
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  bit_cnt, bit_cnt_nxt;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic [31:0] rx_word;
    logic [31:0] hrdata_q;
    logic [21:0] stream_word_addr;
    logic [21:0] req_word_addr;

    logic aphase, rd_aphase, wr_aphase;
    logic seq_hit, accepting, load_addr, load_cmd;
    logic hready_resp, hresp;
    logic cs_active_nxt, sclk_nxt;

    assign aphase        = ahbls.hready && ahbls.htrans[1];
    assign rd_aphase     = aphase && !ahbls.hwrite;
    assign wr_aphase     = aphase && ahbls.hwrite;
    assign req_word_addr = ahbls.haddr[23:2];

    // Widened by one bit so the 0x3FFFFF -> 0 wrap is never treated as sequential.
    assign seq_hit = ({1'b0, req_word_addr} == ({1'b0, stream_word_addr} + 23'd1));

    assign accepting = (state == S_IDLE) || (state == S_RESP) || (state == S_ERR_PH1);
    assign load_addr = rd_aphase && accepting;
    assign load_cmd  = load_addr && !((state == S_RESP) && seq_hit);

    assign rx_word = {rx_sr[30:0], spi_miso};

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        hready_resp = 1'b0;
        hresp       = 1'b0;
        case (state)
            S_IDLE: begin
                hready_resp = 1'b1;
                if (rd_aphase)      state_nxt = S_SETUP;
                else if (wr_aphase) state_nxt = S_ERR_PH0;
            end
            S_SETUP:   state_nxt = S_CMDADDR;
            S_CMDADDR: if (bit_cnt == 6'd63) state_nxt = S_DATA;
            S_DATA:    if (bit_cnt == 6'd63) state_nxt = S_RESP;
            S_RESP: begin
                hready_resp = 1'b1;
                if (rd_aphase && seq_hit) state_nxt = S_DATA;
                else if (rd_aphase)       state_nxt = S_GAP;
                else if (wr_aphase)       state_nxt = S_ERR_PH0;
                else                      state_nxt = S_IDLE;
            end
            S_GAP:     state_nxt = S_SETUP;
            S_ERR_PH0: begin
                hresp     = 1'b1;
                state_nxt = S_ERR_PH1;
            end
            S_ERR_PH1: begin
                hready_resp = 1'b1;
                hresp       = 1'b1;
                if (rd_aphase)      state_nxt = S_SETUP;
                else if (wr_aphase) state_nxt = S_ERR_PH0;
                else                state_nxt = S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Bit-pair counter runs only while clocking the flash; its LSB selects the sclk phase.
    assign bit_cnt_nxt   = ((state == S_CMDADDR) || (state == S_DATA)) ? bit_cnt + 6'd1 : 6'd0;
    assign cs_active_nxt = state_nxt inside {S_SETUP, S_CMDADDR, S_DATA, S_RESP};
    assign sclk_nxt      = (state_nxt inside {S_CMDADDR, S_DATA}) && bit_cnt_nxt[0];

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the shifters and read-data register are reset too, keeping pins and hrdata defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            bit_cnt          <= 6'd0;
            tx_sr            <= 32'd0;
            rx_sr            <= 32'd0;
            hrdata_q         <= 32'd0;
            stream_word_addr <= 22'd0;
            spi_cs_n         <= 1'b1;
            spi_sclk         <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            spi_cs_n <= !cs_active_nxt;
            spi_sclk <= sclk_nxt;

            if (load_addr) stream_word_addr <= req_word_addr;

            // Command word is staged at address acceptance so its MSB is on mosi during SETUP.
            if (load_cmd)
                tx_sr <= {CMD_READ, req_word_addr, 2'b00};
            else if ((state == S_CMDADDR) && bit_cnt[0])
                tx_sr <= {tx_sr[30:0], 1'b0};

            if ((state == S_DATA) && bit_cnt[0]) rx_sr <= rx_word;

            // Flash streams byte +0 first; AHB wants it in the low lane.
            if ((state == S_DATA) && (bit_cnt == 6'd63))
                hrdata_q <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
        end
    end

    assign spi_mosi          = tx_sr[31];
    assign ahbls.hready_resp = hready_resp;
    assign ahbls.hresp       = hresp;
    assign ahbls.hrdata      = W_DATA'(hrdata_q);

    // Attributes the flash cannot act on; the master selects bytes from the full word.
    logic unused_bus;
    assign unused_bus = ^{ahbls.hsize, ahbls.hburst, ahbls.hprot, ahbls.hmastlock,
                          ahbls.hwdata, ahbls.htrans[0], ahbls.haddr[W_ADDR-1:24],
                          ahbls.haddr[1:0]};
endmodule

// File: tb/tb_ahb_spi_flash_xip.sv
// Bench for ahb_spi_flash_xip: AHB driver with a latency/data scoreboard, a behavioural
// SPI flash, directed scenarios and a randomized transfer mix.
module tb_ahb_spi_flash_xip;
    localparam logic [1:0] HT_IDLE = 2'd0;
    localparam logic [1:0] HT_NSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ  = 2'd3;

    logic clk;
    logic rst_n;
    logic spi_cs_n, spi_sclk, spi_mosi, spi_miso;

    ahb_spi_flash_xip_if #(.W_ADDR(32), .W_DATA(32)) bus ();
    assign bus.hready = bus.hready_resp;

    ahb_spi_flash_xip #(.W_ADDR(32), .W_DATA(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ahbls    (bus),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_bench();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // ---------------- flash content and behavioural flash ----------------
    logic [7:0] preset [logic [23:0]];

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        logic [7:0] m;
        if (preset.exists(a)) return preset[a];
        m = a[7:0] * 8'd37;
        return m ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h5A;
    endfunction

    function automatic logic [31:0] exp_word(input logic [21:0] w);
        logic [23:0] a;
        a = {w, 2'b00};
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    logic [31:0] cmd_log [$];
    logic [31:0] cmd_sr   = 32'd0;
    int          bitcnt   = 0;
    int          dcnt     = 0;
    logic [23:0] faddr    = 24'd0;
    logic [7:0]  fb;

    initial spi_miso = 1'b0;

    // Mode 0: sample mosi on sclk rise, present the next data bit after sclk falls.
    always @(posedge spi_sclk or negedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            bitcnt = 0;
            dcnt   = 0;
        end else if (spi_sclk) begin
            if (bitcnt < 32) begin
                cmd_sr = {cmd_sr[30:0], spi_mosi};
                bitcnt++;
                if (bitcnt == 32) begin
                    cmd_log.push_back(cmd_sr);
                    faddr = cmd_sr[23:0];
                end
            end
        end else if (bitcnt == 32) begin
            #1;
            fb       = fbyte(faddr + 24'(dcnt / 8));
            spi_miso = fb[7 - (dcnt % 8)];
            dcnt++;
        end
    end

    // ---------------- chip-select activity monitor ----------------
    logic cs_prev     = 1'b1;
    int   cs_high_run = 0;
    int   last_gap    = -1;
    int   cs_rises    = 0;
    int   cs_falls    = 0;
    int   rise_cycle  = -1;
    int   resp_cycle  = -1;

    always @(negedge clk) begin
        if (spi_cs_n && !cs_prev) begin
            cs_rises++;
            rise_cycle = cyc;
        end
        if (!spi_cs_n && cs_prev) begin
            cs_falls++;
            last_gap = cs_high_run;
        end
        cs_high_run = spi_cs_n ? cs_high_run + 1 : 0;
        cs_prev     = spi_cs_n;
    end

    // ---------------- reference model and scoreboard ----------------
    typedef enum {K_IDLE, K_READ, K_WRITE} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t        exp_q [$];
    kind_t       prev_kind = K_IDLE;
    logic [21:0] prev_w    = 22'd0;
    int          mon_waits = 0;

    // Latency rules: fresh command 129 waits; next word of an open stream 64; a
    // non-sequential read landing on a completing read pays one extra GAP cycle.
    function automatic int read_waits(input logic [21:0] w);
        if (prev_kind != K_READ) return 129;
        if ({1'b0, w} == ({1'b0, prev_w} + 23'd1)) return 64;
        return 130;
    endfunction

    task automatic issue(input logic [31:0] a, input logic wr, input logic [1:0] tr);
        exp_t e;
        logic rdy;
        int   n;
        bus.haddr     = a;
        bus.hwrite    = wr;
        bus.htrans    = tr;
        bus.hsize     = 3'($urandom_range(0, 2));
        bus.hburst    = 3'($urandom);
        bus.hprot     = 4'($urandom);
        bus.hmastlock = 1'($urandom);
        bus.hwdata    = $urandom;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = bus.hready_resp;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 300) begin
                check("accept_timeout", 32'(n), 32'd0);
                finish_bench();
            end
        end
        e.data = 32'd0;
        if (!tr[1]) begin
            e.kind    = K_IDLE;
            e.waits   = 0;
            prev_kind = K_IDLE;
        end else if (wr) begin
            e.kind    = K_WRITE;
            e.waits   = 1;
            prev_kind = K_WRITE;
        end else begin
            e.kind    = K_READ;
            e.waits   = read_waits(a[23:2]);
            e.data    = exp_word(a[23:2]);
            prev_kind = K_READ;
            prev_w    = a[23:2];
        end
        exp_q.push_back(e);
    endtask

    exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_waits = 0;
        end else if (exp_q.size() != 0) begin
            if (!bus.hready_resp) begin
                if (mon_waits == 0 && exp_q[0].kind == K_WRITE)
                    check("err_first_cycle_hresp", 32'(bus.hresp), 32'd1);
                mon_waits++;
            end else begin
                cur = exp_q.pop_front();
                check("wait_states", 32'(mon_waits), 32'(cur.waits));
                check("hresp", 32'(bus.hresp), 32'(cur.kind == K_WRITE));
                if (cur.kind == K_READ) begin
                    check("hrdata", bus.hrdata, cur.data);
                    resp_cycle = cyc;
                end
                mon_waits = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int          n, cmd0, rise0, fall0, r;
    logic [31:0] a;

    initial begin
        rst_n = 1'b0;
        bus.haddr = 32'd0; bus.hwrite = 1'b0; bus.htrans = HT_IDLE; bus.hsize = 3'd2;
        bus.hburst = 3'd0; bus.hprot = 4'd0; bus.hmastlock = 1'b0; bus.hwdata = 32'd0;
        preset[24'h000104] = 8'h11;
        preset[24'h000105] = 8'h22;
        preset[24'h000106] = 8'h33;
        preset[24'h000107] = 8'h44;

        #12;
        check("reset_cs_n",   32'(spi_cs_n), 32'd1);
        check("reset_sclk",   32'(spi_sclk), 32'd0);
        check("reset_mosi",   32'(spi_mosi), 32'd0);
        check("reset_hready", 32'(bus.hready_resp), 32'd1);
        check("reset_hresp",  32'(bus.hresp), 32'd0);
        check("reset_hrdata", bus.hrdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read from idle
        cmd0 = cmd_log.size();
        issue(32'h0000_0104, 1'b0, HT_NSEQ);
        issue(32'h0, 1'b0, HT_IDLE);
        issue(32'h0, 1'b0, HT_IDLE);
        check("t1_cmd_count", 32'(cmd_log.size() - cmd0), 32'd1);
        check("t1_cmd_word", cmd_log[cmd_log.size() - 1], 32'h0300_0104);
        check("t1_cs_rise_after_resp", 32'(rise_cycle), 32'(resp_cycle + 1));

        // INCR4 burst on one command
        cmd0 = cmd_log.size(); rise0 = cs_rises;
        issue(32'h0000_0200, 1'b0, HT_NSEQ);
        issue(32'h0000_0204, 1'b0, HT_SEQ);
        issue(32'h0000_0208, 1'b0, HT_SEQ);
        issue(32'h0000_020C, 1'b0, HT_SEQ);
        issue(32'h0, 1'b0, HT_IDLE);
        issue(32'h0, 1'b0, HT_IDLE);
        check("t2_cmd_count", 32'(cmd_log.size() - cmd0), 32'd1);
        check("t2_cmd_word", cmd_log[cmd_log.size() - 1], 32'h0300_0200);
        check("t2_cs_rises", 32'(cs_rises - rise0), 32'd1);

        // Non-sequential read arriving in RESP
        cmd0 = cmd_log.size();
        issue(32'h0000_0100, 1'b0, HT_NSEQ);
        issue(32'h0000_0400, 1'b0, HT_NSEQ);
        issue(32'h0, 1'b0, HT_IDLE);
        issue(32'h0, 1'b0, HT_IDLE);
        check("t3_cmd_count", 32'(cmd_log.size() - cmd0), 32'd2);
        check("t3_cmd_word", cmd_log[cmd_log.size() - 1], 32'h0300_0400);
        check("t3_gap_cycles", 32'(last_gap), 32'd1);

        // Write error then a normal read
        fall0 = cs_falls;
        issue(32'h0000_0000, 1'b1, HT_NSEQ);
        issue(32'h0000_0300, 1'b0, HT_NSEQ);
        check("t4_no_cs_on_write", 32'(cs_falls - fall0), 32'd0);
        issue(32'h0, 1'b0, HT_IDLE);
        issue(32'h0, 1'b0, HT_IDLE);

        // Wrap at the top of flash is not sequential
        cmd0 = cmd_log.size();
        issue(32'h00FF_FFFC, 1'b0, HT_NSEQ);
        issue(32'h0000_0000, 1'b0, HT_SEQ);
        issue(32'h0, 1'b0, HT_IDLE);
        issue(32'h0, 1'b0, HT_IDLE);
        check("t5_cmd_count", 32'(cmd_log.size() - cmd0), 32'd2);
        check("t5_cmd_word", cmd_log[cmd_log.size() - 1], 32'h0300_0000);
        check("t5_gap_cycles", 32'(last_gap), 32'd1);

        // Randomized mix of streams, jumps, wraps, writes and idle/busy
        for (int i = 0; i < 48; i++) begin
            r = $urandom_range(0, 99);
            if (prev_kind == K_READ && r < 45)
                a = {8'($urandom), prev_w + 22'd1, 2'($urandom)};
            else if (r < 50)
                a = {8'($urandom), 22'h3FFFFF, 2'($urandom)};
            else
                a = $urandom;
            if (r < 75)      issue(a, 1'b0, (r < 45) ? HT_SEQ : HT_NSEQ);
            else if (r < 85) issue(a, 1'b1, HT_NSEQ);
            else             issue(a, 1'b0, 2'($urandom_range(0, 1)));
        end
        issue(32'h0, 1'b0, HT_IDLE);
        issue(32'h0, 1'b0, HT_IDLE);

        // Asynchronous reset in the middle of the data phase
        issue(32'h0000_0104, 1'b0, HT_NSEQ);
        bus.htrans = HT_IDLE;
        repeat (100) @(posedge clk);
        check("t6_cs_low_before_reset", 32'(spi_cs_n), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_cs_n",   32'(spi_cs_n), 32'd1);
        check("t6_rst_sclk",   32'(spi_sclk), 32'd0);
        check("t6_rst_hready", 32'(bus.hready_resp), 32'd1);
        exp_q.delete();
        mon_waits = 0;
        prev_kind = K_IDLE;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h0000_0104, 1'b0, HT_NSEQ);
        issue(32'h0, 1'b0, HT_IDLE);

        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        finish_bench();
    end
endmodule
